// File: rtl/msrv32_pkg.sv
// Shared ALU opcode constants and the issue-entry record for the msrv32 ALU issue stage.
package msrv32_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef struct packed {
        logic [3:0]      opcode;
        logic [4:0]      rd;
        logic            rd_we;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            src1_pc;
        logic            src2_imm;
        logic [XLEN-1:0] op_1;
        logic [XLEN-1:0] op_2;
    } issue_entry_t;

endpackage

// File: rtl/msrv32_operand_bypass.sv
// Single-operand forwarding select: swaps in the departing producer's ALU result when the
// operand is register-sourced and its rs index matches a non-x0 producer destination.
module msrv32_operand_bypass
    import msrv32_pkg::*;
(
    input  logic [4:0]      rs,
    input  logic            reg_src,
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      prod_rd,
    input  logic            prod_we,
    input  logic [XLEN-1:0] result,
    output logic [XLEN-1:0] data_out
);

    logic hit;

    assign hit      = prod_we && reg_src && (prod_rd != 5'd0) && (rs == prod_rd);
    assign data_out = hit ? result : data_in;

endmodule

// File: rtl/msrv32_alu_issue.sv
// ALU issue stage: operand select, two-entry registered skid buffer and optional forwarding.
// Forwarding from the departing entry is built only when MSRV32_ISSUE_BYPASS_EN is defined.
module msrv32_alu_issue
    import msrv32_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            in_valid_in,
    output logic            in_ready_out,
    input  logic [3:0]      opcode_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            src1_pc_in,
    input  logic            src2_imm_in,
    input  logic            rd_we_in,
    output logic            out_valid_out,
    input  logic            out_ready_in,
    output logic [XLEN-1:0] op_1_out,
    output logic [XLEN-1:0] op_2_out,
    output logic [3:0]      opcode_out,
    output logic [4:0]      rd_out,
    output logic            rd_we_out,
    input  logic [XLEN-1:0] result_in
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      state_reg, state_next;
    issue_entry_t    out_reg, skid_reg, in_entry, skid_fwd;
    logic            in_fire, out_fire;
    logic [XLEN-1:0] in_op1_raw, in_op2_raw;
    logic [XLEN-1:0] in_op1, in_op2, skid_op1, skid_op2;
    logic            unused_fields;

    assign out_valid_out = (state_reg != ST_EMPTY);
    assign in_ready_out  = (state_reg != ST_FULL);
    assign in_fire       = in_valid_in & in_ready_out;
    assign out_fire      = out_valid_out & out_ready_in;

    assign in_op1_raw = src1_pc_in  ? pc_in  : rs1_data_in;
    assign in_op2_raw = src2_imm_in ? imm_in : rs2_data_in;

`ifdef MSRV32_ISSUE_BYPASS_EN
    // Slot order: incoming op_1, incoming op_2, skid op_1, skid op_2.
    logic [3:0][4:0]      sel_rs;
    logic [3:0]           sel_reg;
    logic [3:0][XLEN-1:0] sel_in;
    logic [3:0][XLEN-1:0] sel_out;
    logic                 prod_we;

    assign prod_we = out_fire & out_reg.rd_we;
    assign sel_rs  = {skid_reg.rs2, skid_reg.rs1, rs2_in, rs1_in};
    assign sel_reg = {~skid_reg.src2_imm, ~skid_reg.src1_pc, ~src2_imm_in, ~src1_pc_in};
    assign sel_in  = {skid_reg.op_2, skid_reg.op_1, in_op2_raw, in_op1_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byp
            msrv32_operand_bypass u_byp (
                .rs       (sel_rs[gi]),
                .reg_src  (sel_reg[gi]),
                .data_in  (sel_in[gi]),
                .prod_rd  (out_reg.rd),
                .prod_we  (prod_we),
                .result   (result_in),
                .data_out (sel_out[gi])
            );
        end
    endgenerate

    assign in_op1   = sel_out[0];
    assign in_op2   = sel_out[1];
    assign skid_op1 = sel_out[2];
    assign skid_op2 = sel_out[3];
    assign unused_fields = ^{out_reg.rs1, out_reg.rs2, out_reg.src1_pc, out_reg.src2_imm};
`else
    assign in_op1   = in_op1_raw;
    assign in_op2   = in_op2_raw;
    assign skid_op1 = skid_reg.op_1;
    assign skid_op2 = skid_reg.op_2;
    assign unused_fields = ^{out_reg.rs1, out_reg.rs2, out_reg.src1_pc, out_reg.src2_imm,
                             skid_reg.rs1, skid_reg.rs2, skid_reg.src1_pc, skid_reg.src2_imm,
                             result_in};
`endif

    always_comb begin
        in_entry          = '0;
        in_entry.opcode   = opcode_in;
        in_entry.rd       = rd_in;
        in_entry.rd_we    = rd_we_in;
        in_entry.rs1      = rs1_in;
        in_entry.rs2      = rs2_in;
        in_entry.src1_pc  = src1_pc_in;
        in_entry.src2_imm = src2_imm_in;
        in_entry.op_1     = in_op1;
        in_entry.op_2     = in_op2;

        skid_fwd      = skid_reg;
        skid_fwd.op_1 = skid_op1;
        skid_fwd.op_2 = skid_op2;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (in_fire) state_next = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire)      state_next = ST_FULL;
                else if (!in_fire && out_fire) state_next = ST_EMPTY;
            end
            ST_FULL:  if (out_fire) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= ST_EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_EMPTY: if (in_fire) out_reg <= in_entry;
                ST_ONE: begin
                    if (in_fire && out_fire) out_reg  <= in_entry;
                    else if (in_fire)        skid_reg <= in_entry;
                end
                ST_FULL:  if (out_fire) out_reg <= skid_fwd;
                default: ;
            endcase
        end
    end

    assign op_1_out   = out_reg.op_1;
    assign op_2_out   = out_reg.op_2;
    assign opcode_out = out_reg.opcode;
    assign rd_out     = out_reg.rd;
    assign rd_we_out  = out_reg.rd_we;

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Directed self-checking bench for msrv32_alu_issue; forwarding expectations follow
// whether MSRV32_ISSUE_BYPASS_EN is defined for the build.
module tb_msrv32_alu_issue;
    import msrv32_pkg::*;

`ifdef MSRV32_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            in_valid_in;
    logic            in_ready_out;
    logic [3:0]      opcode_in;
    logic [4:0]      rs1_in, rs2_in, rd_in;
    logic [XLEN-1:0] rs1_data_in, rs2_data_in, pc_in, imm_in;
    logic            src1_pc_in, src2_imm_in, rd_we_in;
    logic            out_valid_out;
    logic            out_ready_in;
    logic [XLEN-1:0] op_1_out, op_2_out;
    logic [3:0]      opcode_out;
    logic [4:0]      rd_out;
    logic            rd_we_out;
    logic [XLEN-1:0] result_in;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    msrv32_alu_issue dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .opcode_in     (opcode_in),
        .rs1_in        (rs1_in),
        .rs2_in        (rs2_in),
        .rd_in         (rd_in),
        .rs1_data_in   (rs1_data_in),
        .rs2_data_in   (rs2_data_in),
        .pc_in         (pc_in),
        .imm_in        (imm_in),
        .src1_pc_in    (src1_pc_in),
        .src2_imm_in   (src2_imm_in),
        .rd_we_in      (rd_we_in),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .op_1_out      (op_1_out),
        .op_2_out      (op_2_out),
        .opcode_out    (opcode_out),
        .rd_out        (rd_out),
        .rd_we_out     (rd_we_out),
        .result_in     (result_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic offer(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2, input logic s1pc,
                         input logic s2imm, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rd, input logic we);
        in_valid_in = 1'b1;
        opcode_in   = op;
        rs1_in      = rs1;
        rs1_data_in = d1;
        rs2_in      = rs2;
        rs2_data_in = d2;
        src1_pc_in  = s1pc;
        src2_imm_in = s2imm;
        pc_in       = pc;
        imm_in      = imm;
        rd_in       = rd;
        rd_we_in    = we;
    endtask

    task automatic check_zero_outputs(input string pfx);
        chk({pfx, "_valid"}, {31'd0, out_valid_out}, 32'd0);
        chk({pfx, "_ready"}, {31'd0, in_ready_out}, 32'd1);
        chk({pfx, "_op1"}, op_1_out, 32'd0);
        chk({pfx, "_op2"}, op_2_out, 32'd0);
        chk({pfx, "_opc"}, {28'd0, opcode_out}, 32'd0);
        chk({pfx, "_rd"}, {27'd0, rd_out}, 32'd0);
        chk({pfx, "_we"}, {31'd0, rd_we_out}, 32'd0);
    endtask

    initial begin
        rst_n_in     = 1'b0;
        in_valid_in  = 1'b0;
        out_ready_in = 1'b0;
        result_in    = '0;
        offer(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid_in  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_in);
        check_zero_outputs("rst");
        rst_n_in = 1'b1;

        // Basic capture: ADD rs1_data=5, imm=7
        offer(ALU_ADD, 5'd1, 32'd5, 5'd9, 32'hFFFF, 1'b0, 1'b1, 32'h100, 32'd7, 5'd2, 1'b1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        chk("t1_valid", {31'd0, out_valid_out}, 32'd1);
        chk("t1_op1", op_1_out, 32'd5);
        chk("t1_op2", op_2_out, 32'd7);
        chk("t1_opc", {28'd0, opcode_out}, {28'd0, ALU_ADD});
        chk("t1_rd", {27'd0, rd_out}, 32'd2);

        // Backpressure: second goes to SKID, third is held off
        offer(ALU_SUB, 5'd5, 32'h11, 5'd6, 32'h22, 1'b0, 1'b0, 0, 0, 5'd4, 1'b1);
        @(negedge clk_in);
        chk("t2_full_ready", {31'd0, in_ready_out}, 32'd0);
        chk("t2_hold_op1", op_1_out, 32'd5);
        offer(ALU_XOR, 5'd7, 32'h33, 5'd8, 32'h44, 1'b0, 1'b0, 0, 0, 5'd11, 1'b1);
        @(negedge clk_in);
        chk("t2_stall_op1", op_1_out, 32'd5);
        chk("t2_stall_op2", op_2_out, 32'd7);
        chk("t2_stall_rdy", {31'd0, in_ready_out}, 32'd0);
        out_ready_in = 1'b1;
        @(negedge clk_in);
        chk("t2_skid_op1", op_1_out, 32'h11);
        chk("t2_skid_op2", op_2_out, 32'h22);
        chk("t2_skid_opc", {28'd0, opcode_out}, {28'd0, ALU_SUB});
        chk("t2_skid_rdy", {31'd0, in_ready_out}, 32'd1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        chk("t2_third_op1", op_1_out, 32'h33);
        chk("t2_third_op2", op_2_out, 32'h44);
        chk("t2_third_opc", {28'd0, opcode_out}, {28'd0, ALU_XOR});
        @(negedge clk_in);
        chk("t2_drain_vld", {31'd0, out_valid_out}, 32'd0);

        // Back-to-back: producer ADD x3, consumer SUB rs1=x3 with stale data
        offer(ALU_ADD, 5'd1, 32'd8, 5'd2, 32'd8, 1'b0, 1'b0, 0, 0, 5'd3, 1'b1);
        @(negedge clk_in);
        chk("t3_prod_op1", op_1_out, 32'd8);
        result_in = 32'h10;
        offer(ALU_SUB, 5'd3, 32'd0, 5'd9, 32'd5, 1'b0, 1'b0, 0, 0, 5'd10, 1'b1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        chk("t3_byp_op1", op_1_out, BYP ? 32'h10 : 32'h0);
        chk("t3_byp_op2", op_2_out, 32'd5);
        chk("t3_rd", {27'd0, rd_out}, 32'd10);
        @(negedge clk_in);

        // SKID depends on OUT (rs2=x3)
        out_ready_in = 1'b0;
        offer(ALU_OR, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 1'b0, 0, 0, 5'd3, 1'b1);
        @(negedge clk_in);
        offer(ALU_AND, 5'd4, 32'h22, 5'd3, 32'h1111, 1'b0, 1'b0, 0, 0, 5'd5, 1'b1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        chk("t4_full_rdy", {31'd0, in_ready_out}, 32'd0);
        result_in    = 32'hABCD;
        out_ready_in = 1'b1;
        @(negedge clk_in);
        chk("t4_skid_op2", op_2_out, BYP ? 32'hABCD : 32'h1111);
        chk("t4_skid_op1", op_1_out, 32'h22);
        chk("t4_skid_rd", {27'd0, rd_out}, 32'd5);
        @(negedge clk_in);

        // x0 producer never forwards
        offer(ALU_ADD, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 1'b0, 0, 0, 5'd0, 1'b1);
        @(negedge clk_in);
        result_in = 32'hDEAD;
        offer(ALU_SLT, 5'd0, 32'h77, 5'd0, 32'h0, 1'b0, 1'b1, 0, 32'h5, 5'd6, 1'b1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        chk("t5_x0_op1", op_1_out, 32'h77);
        chk("t5_imm_op2", op_2_out, 32'h5);
        @(negedge clk_in);

        // Reset while FULL
        out_ready_in = 1'b0;
        offer(ALU_SRA, 5'd1, 32'h9, 5'd2, 32'h8, 1'b1, 1'b0, 32'h40, 0, 5'd7, 1'b1);
        @(negedge clk_in);
        offer(ALU_SLL, 5'd1, 32'h9, 5'd2, 32'h8, 1'b0, 1'b0, 0, 0, 5'd8, 1'b1);
        @(negedge clk_in);
        in_valid_in = 1'b0;
        chk("t6_pc_op1", op_1_out, 32'h40);
        chk("t6_full_rdy", {31'd0, in_ready_out}, 32'd0);
        #2 rst_n_in = 1'b0;
        #1 check_zero_outputs("t6_rst");
        @(negedge clk_in);
        rst_n_in     = 1'b1;
        out_ready_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("t6_post_vld", {31'd0, out_valid_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
